// File: rtl/seq_shift_stage_pkg.sv
// seq_shift_stage_pkg: shared widths, state encoding and bit-order helper for the shift stage
package seq_shift_stage_pkg;
  localparam int WIDTH = 16;
  localparam int SHW = $clog2(WIDTH);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE = ST_DONE
  } state_t;
  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int k = 0; k < WIDTH; k++) r[k] = v[WIDTH-1-k];
    return r;
  endfunction
endpackage

// File: rtl/seq_shift_stage_if.sv
// seq_shift_stage_if: start/busy/done job interface for the iterative shifter
interface seq_shift_stage_if;
  import seq_shift_stage_pkg::*;
  logic start;
  logic [WIDTH-1:0] din;
  logic [SHW-1:0] shamt;
  logic fill;
  logic busy;
  logic done;
  logic [WIDTH-1:0] dout;
  modport master (output start, din, shamt, fill, input busy, done, dout);
  modport slave (input start, din, shamt, fill, output busy, done, dout);
endinterface

// File: rtl/seq_shift_stage_mux2.sv
// seq_shift_stage_mux2: single-bit 2:1 mux cell, y = sel ? b : a
module seq_shift_stage_mux2 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/seq_shift_stage.sv
// seq_shift_stage: iterative left shifter, one bit per clock, with start/busy/done handshake
module seq_shift_stage
  import seq_shift_stage_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  seq_shift_stage_if.slave bus
);
  state_t state;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] work_nxt;
  logic [SHW-1:0] cnt;
  logic fill_q;
  logic busy_q;
  logic done_q;
  logic [WIDTH-1:0] dout_q;
  logic shifting;

  assign shifting = (state == S_SHIFT);
  assign shifted = {work[WIDTH-2:0], fill_q};

  genvar i;
  for (i = 0; i < WIDTH; i++) begin : g_bit
    seq_shift_stage_mux2 u_mux (
      .a(work[i]),
      .b(shifted[i]),
      .sel(shifting),
      .y(work_nxt[i])
    );
  end

  // FSM with registered outputs; dout is loaded on entry to DONE so it is valid alongside done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      work <= '0;
      cnt <= '0;
      fill_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dout_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            work <= bus.din;
            cnt <= bus.shamt;
            fill_q <= bus.fill;
            busy_q <= 1'b1;
            if (bus.shamt == '0) begin
              state <= S_DONE;
              dout_q <= bus.din;
              done_q <= 1'b1;
            end else begin
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          work <= work_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == SHW'(1)) begin
            state <= S_DONE;
            dout_q <= work_nxt;
            done_q <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dout = dout_q;
endmodule

// File: tb/tb_seq_shift_stage.sv
// tb_seq_shift_stage: directed self-checking bench for the iterative shifter
module tb_seq_shift_stage;
  import seq_shift_stage_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  seq_shift_stage_if bus ();
  seq_shift_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic do_job(input logic [15:0] d, input logic [3:0] s, input logic f,
                        output logic [15:0] res, output int lat, output int bcnt,
                        output logic post_done, output logic post_busy);
    bus.start = 1'b1; bus.din = d; bus.shamt = s; bus.fill = f;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.din = 16'hDEAD; bus.shamt = 4'd7; bus.fill = ~f;
    lat = 1; bcnt = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (bus.busy) bcnt++;
    res = bus.dout;
    @(negedge clk);
    post_done = bus.done; post_busy = bus.busy;
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.din = '0; bus.shamt = '0; bus.fill = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.done); end
    vectors++; if (bus.dout !== 16'h0000) begin miscompares++; $display("FAIL reset_dout got %h want 0000", bus.dout); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [15:0] r; int lat, bc; logic pd, pb;
    do_job(16'h0001, 4'd4, 1'b0, r, lat, bc, pd, pb);
    vectors++; if (r !== 16'h0010) begin miscompares++; $display("FAIL basic_dout got %h want 0010", r); end
    vectors++; if (lat != 5) begin miscompares++; $display("FAIL basic_latency got %0d want 5", lat); end
    vectors++; if (bc != 5) begin miscompares++; $display("FAIL basic_busy_cycles got %0d want 5", bc); end
    vectors++; if (pd !== 1'b0 || pb !== 1'b0) begin miscompares++; $display("FAIL basic_after_done got done=%b busy=%b want 0 0", pd, pb); end
    vectors++; if (bus.dout !== 16'h0010) begin miscompares++; $display("FAIL basic_hold got %h want 0010", bus.dout); end
  endtask

  task automatic test_zero_shift;
    logic [15:0] r; int lat, bc; logic pd, pb;
    do_job(16'hA5A5, 4'd0, 1'b1, r, lat, bc, pd, pb);
    vectors++; if (r !== 16'hA5A5) begin miscompares++; $display("FAIL zero_dout got %h want a5a5", r); end
    vectors++; if (lat != 1) begin miscompares++; $display("FAIL zero_latency got %0d want 1", lat); end
    vectors++; if (bc != 1) begin miscompares++; $display("FAIL zero_busy_cycles got %0d want 1", bc); end
    vectors++; if (pd !== 1'b0 || pb !== 1'b0) begin miscompares++; $display("FAIL zero_after_done got done=%b busy=%b want 0 0", pd, pb); end
  endtask

  task automatic test_full_shift;
    logic [15:0] r; int lat, bc; logic pd, pb;
    do_job(16'h8001, 4'd15, 1'b0, r, lat, bc, pd, pb);
    vectors++; if (r !== 16'h8000) begin miscompares++; $display("FAIL full_logical got %h want 8000", r); end
    vectors++; if (lat != 16) begin miscompares++; $display("FAIL full_latency got %0d want 16", lat); end
    do_job(16'h7FFF, 4'd15, 1'b1, r, lat, bc, pd, pb);
    vectors++; if (r !== 16'hFFFF) begin miscompares++; $display("FAIL full_fill1 got %h want ffff", r); end
  endtask

  task automatic test_ignore_start;
    int dones = 0;
    bus.start = 1'b1; bus.din = 16'h00FF; bus.shamt = 4'd8; bus.fill = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
      if (k == 5) begin
        vectors++; if (bus.dout !== 16'hFFFF) begin miscompares++; $display("FAIL ignore_hold_prev got %h want ffff", bus.dout); end
      end
      bus.start = (k == 2 || k == 9);
      bus.din = 16'hFFFF; bus.shamt = 4'd1; bus.fill = 1'b1;
    end
    vectors++; if (dones != 1) begin miscompares++; $display("FAIL ignore_done_count got %0d want 1", dones); end
    vectors++; if (bus.dout !== 16'hFF00) begin miscompares++; $display("FAIL ignore_dout got %h want ff00", bus.dout); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL ignore_idle_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid_job;
    logic [15:0] r; int lat, bc; logic pd, pb;
    bus.start = 1'b1; bus.din = 16'h1234; bus.shamt = 4'd10; bus.fill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dout !== 16'h0000) begin
      miscompares++; $display("FAIL midreset_outputs got busy=%b done=%b dout=%h want 0 0 0000", bus.busy, bus.done, bus.dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_job(16'h0003, 4'd1, 1'b0, r, lat, bc, pd, pb);
    vectors++; if (r !== 16'h0006) begin miscompares++; $display("FAIL midreset_newjob got %h want 0006", r); end
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL midreset_latency got %0d want 2", lat); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] r; int lat, bc; logic pd, pb;
    do_job(16'h0003, 4'd2, 1'b1, r, lat, bc, pd, pb);
    vectors++; if (r !== 16'h000F) begin miscompares++; $display("FAIL b2b_first got %h want 000f", r); end
    do_job(16'h0F0F, 4'd4, 1'b0, r, lat, bc, pd, pb);
    vectors++; if (r !== 16'hF0F0) begin miscompares++; $display("FAIL b2b_second got %h want f0f0", r); end
    vectors++; if (lat != 5) begin miscompares++; $display("FAIL b2b_latency got %0d want 5", lat); end
  endtask

  task automatic test_right_chain;
    logic [15:0] r; int lat, bc; logic pd, pb;
    do_job(bit_rev(16'h8000), 4'd3, 1'b0, r, lat, bc, pd, pb);
    vectors++; if (bit_rev(r) !== 16'h1000) begin miscompares++; $display("FAIL chain_right got %h want 1000", bit_rev(r)); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero_shift;
    test_full_shift;
    test_ignore_start;
    test_reset_mid_job;
    test_back_to_back;
    test_right_chain;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
